arb2_stream: RTL



---
 rtl/arb2_stream.sv | 102 ++++++++++
 1 files changed

// File: rtl/arb2_stream.sv
// Two-source round-robin arbiter with optional burst hold, feeding a one-entry registered output stage.
// One-cycle latency, one beat per cycle; while a stalled beat waits for y_ready both input readies stay low.
module arb2_stream #(
  parameter int W     = 8,
  parameter int BURST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i0_data,
  input  logic         i0_valid,
  output logic         i0_ready,
  input  logic [W-1:0] i1_data,
  input  logic         i1_valid,
  output logic         i1_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         s
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  logic         last_q, last_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         y_valid_q, y_valid_d;
  logic [W-1:0] y_data_q, y_data_d;
  logic         s_q, s_d;

  logic         load;
  logic         accept;
  logic         g;
  logic         last_vld;
  logic         burst_cont;
  logic [3:0]   cnt_inc;

  assign load       = !y_valid_q || y_ready;
  assign last_vld   = last_q ? i1_valid : i0_valid;
  assign burst_cont = (cnt_q != 4'd0) && last_vld;
  assign accept     = load && (i0_valid || i1_valid);
  assign cnt_inc    = cnt_q + 4'd1;

  // An open burst keeps its owner; otherwise a tie goes to the source not served last.
  always_comb begin
    g = i1_valid;
    if (burst_cont) begin
      g = last_q;
    end else if (i0_valid && i1_valid) begin
      g = !last_q;
    end
  end

  // Readies are forced low during reset so nothing is handed over while the stage is being cleared.
  assign i0_ready = !rst && load && i0_valid && !g;
  assign i1_ready = !rst && load && i1_valid && g;

  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    s_d       = s_q;
    if (accept) begin
      y_data_d  = g ? i1_data : i0_data;
      s_d       = g;
      y_valid_d = 1'b1;
      if ((g == last_q) && (cnt_q != 4'd0)) begin
        cnt_d = (cnt_inc == BURST_L) ? 4'd0 : cnt_inc;
      end else begin
        last_d = g;
        cnt_d  = (BURST == 1) ? 4'd0 : 4'd1;
      end
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      s_q       <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      s_q       <= s_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign s       = s_q;

  a_one_ready: assert property (@(posedge clk) disable iff (rst) !(i0_ready && i1_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (y_valid && !y_ready) |=> (y_valid && $stable(y_data) && $stable(s)));

endmodule
